alu_share_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the shared 32-bit combinational ALU. It accepts operation requests from two independent requesters over valid/ready handshakes and grants them round-robin. It drives the ALU inputs from registered operands, captures `out`/`zero` one cycle later, and returns the result to the owning requester with backpressure. It sits between the requester logic (e.g. a multi-cycle execute stage and an address/branch helper) and a single ALU instance.

---
 rtl/alu_share_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//
// Lets two requesters share one 32-bit combinational ALU. Requests arrive over
// valid/ready handshakes and are granted round-robin. The winner's operands are
// registered onto the ALU inputs. The ALU result is captured one cycle later
// and held on the response bus until the owning requester accepts it.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   req_valid/req_ready[1:0]   request handshake, bit i = requester i
//   req_in1_*, req_in2_*       operands per requester
//   req_ctl_*, req_sign[1:0]   ALU control code and signed flag per requester
//   rsp_valid/rsp_ready[1:0]   response handshake, bit i = requester i
//   rsp_data, rsp_zero         captured ALU result and zero flag (shared bus)
//   alu_in1/in2/ctl/sign       registered operands driven to the ALU
//   alu_out, alu_zero          ALU result inputs
//   ops_done                   count of completed response handshakes (wraps)
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int CTL_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [DATA_W-1:0] req_in1_0,
    input  logic [DATA_W-1:0] req_in1_1,
    input  logic [DATA_W-1:0] req_in2_0,
    input  logic [DATA_W-1:0] req_in2_1,
    input  logic [CTL_W-1:0]  req_ctl_0,
    input  logic [CTL_W-1:0]  req_ctl_1,
    input  logic [1:0]        req_sign,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_zero,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic [CTL_W-1:0]  alu_ctl,
    output logic              alu_sign,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zero,
    output logic [CNT_W-1:0]  ops_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Registered state and outputs
    state_t              state_q,    state_d;
    logic                prio_q,     prio_d;
    logic                owner_q,    owner_d;
    logic [DATA_W-1:0]   alu_in1_q,  alu_in1_d;
    logic [DATA_W-1:0]   alu_in2_q,  alu_in2_d;
    logic [CTL_W-1:0]    alu_ctl_q,  alu_ctl_d;
    logic                alu_sign_q, alu_sign_d;
    logic [1:0]          rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_zero_q, rsp_zero_d;
    logic [CNT_W-1:0]    ops_done_q, ops_done_d;

    // Combinational helpers
    logic                winner_s;
    logic [1:0]          req_ready_s;
    logic                accept_s;
    logic                rsp_fire_s;
    logic [DATA_W-1:0]   sel_in1_s;
    logic [DATA_W-1:0]   sel_in2_s;
    logic [CTL_W-1:0]    sel_ctl_s;
    logic                sel_sign_s;

    // Pick the winner: a lone valid requester wins, a tie goes to prio.
    always_comb begin
        winner_s = 1'b0;
        if (req_valid == 2'b11) begin
            winner_s = prio_q;
        end else if (req_valid[1]) begin
            winner_s = 1'b1;
        end else begin
            winner_s = 1'b0;
        end
    end

    // Ready is one-hot to the winner, only in IDLE and never while in reset.
    always_comb begin
        req_ready_s = 2'b00;
        if (!reset && (state_q == ST_IDLE) && (req_valid != 2'b00)) begin
            req_ready_s = winner_s ? 2'b10 : 2'b01;
        end else begin
            req_ready_s = 2'b00;
        end
    end

    // Operand mux toward the ALU registers, steered by the winner.
    always_comb begin
        sel_in1_s  = winner_s ? req_in1_1 : req_in1_0;
        sel_in2_s  = winner_s ? req_in2_1 : req_in2_0;
        sel_ctl_s  = winner_s ? req_ctl_1 : req_ctl_0;
        sel_sign_s = winner_s ? req_sign[1] : req_sign[0];
    end

    assign accept_s   = (req_valid & req_ready_s) != 2'b00;
    // Only the owner's ready matters; the other requester's ready is ignored.
    assign rsp_fire_s = (state_q == ST_RESP) && rsp_ready[owner_q];

    // Next-state logic of the IDLE -> EXEC -> RESP sequencer.
    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        owner_d     = owner_q;
        alu_in1_d   = alu_in1_q;
        alu_in2_d   = alu_in2_q;
        alu_ctl_d   = alu_ctl_q;
        alu_sign_d  = alu_sign_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_zero_d  = rsp_zero_q;
        ops_done_d  = ops_done_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    alu_in1_d  = sel_in1_s;
                    alu_in2_d  = sel_in2_s;
                    alu_ctl_d  = sel_ctl_s;
                    alu_sign_d = sel_sign_s;
                    owner_d    = winner_s;
                    state_d    = ST_EXEC;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_EXEC: begin
                // ALU has had a full cycle on stable operands; capture now.
                rsp_data_d  = alu_out;
                rsp_zero_d  = alu_zero;
                rsp_valid_d = owner_q ? 2'b10 : 2'b01;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_fire_s) begin
                    rsp_valid_d = 2'b00;
                    ops_done_d  = ops_done_q + CNT_ONE;
                    // Hand the next tie to the requester just served's peer.
                    prio_d      = ~owner_q;
                    state_d     = ST_IDLE;
                end else begin
                    state_d     = ST_RESP;
                end
            end
            default: begin
                rsp_valid_d = 2'b00;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            prio_q      <= 1'b0;
            owner_q     <= 1'b0;
            alu_in1_q   <= '0;
            alu_in2_q   <= '0;
            alu_ctl_q   <= '0;
            alu_sign_q  <= 1'b0;
            rsp_valid_q <= 2'b00;
            rsp_data_q  <= '0;
            rsp_zero_q  <= 1'b0;
            ops_done_q  <= '0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            owner_q     <= owner_d;
            alu_in1_q   <= alu_in1_d;
            alu_in2_q   <= alu_in2_d;
            alu_ctl_q   <= alu_ctl_d;
            alu_sign_q  <= alu_sign_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_zero_q  <= rsp_zero_d;
            ops_done_q  <= ops_done_d;
        end
    end

    assign req_ready = req_ready_s;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_zero  = rsp_zero_q;
    assign alu_in1   = alu_in1_q;
    assign alu_in2   = alu_in2_q;
    assign alu_ctl   = alu_ctl_q;
    assign alu_sign  = alu_sign_q;
    assign ops_done  = ops_done_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for alu_share_arbiter: directed scenarios followed by randomized
// traffic checked against a transaction-level reference model. A behavioural
// ALU closes the loop from alu_* outputs back to alu_out/alu_zero.
// -----------------------------------------------------------------------------
module tb_alu_share_arbiter;

    localparam int DATA_W = 32;
    localparam int CTL_W  = 5;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [DATA_W-1:0] req_in1_0, req_in1_1, req_in2_0, req_in2_1;
    logic [CTL_W-1:0]  req_ctl_0, req_ctl_1;
    logic [1:0]        req_sign;
    logic [1:0]        rsp_valid;
    logic [1:0]        rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_zero;
    logic [DATA_W-1:0] alu_in1, alu_in2;
    logic [CTL_W-1:0]  alu_ctl;
    logic              alu_sign;
    logic [DATA_W-1:0] alu_out;
    logic              alu_zero;
    logic [CNT_W-1:0]  ops_done;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.DATA_W(DATA_W), .CTL_W(CTL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_in1_0(req_in1_0), .req_in1_1(req_in1_1),
        .req_in2_0(req_in2_0), .req_in2_1(req_in2_1),
        .req_ctl_0(req_ctl_0), .req_ctl_1(req_ctl_1),
        .req_sign(req_sign),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_zero(rsp_zero),
        .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_ctl(alu_ctl), .alu_sign(alu_sign),
        .alu_out(alu_out), .alu_zero(alu_zero),
        .ops_done(ops_done)
    );

    // Behavioural ALU
    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] c, input logic s);
        case (c)
            5'b00000: return a & b;
            5'b00001: return a | b;
            5'b00010: return a + b;
            5'b00110: return a - b;
            5'b00111: return s ? {31'd0, $signed(a) < $signed(b)} : {31'd0, a < b};
            5'b01100: return ~(a | b);
            default:  return a ^ b;
        endcase
    endfunction

    assign alu_out  = alu_f(alu_in1, alu_in2, alu_ctl, alu_sign);
    assign alu_zero = (alu_out == 32'd0);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [4:0]  ctl_tab [6];
    logic        grants[$];
    // reference model state
    logic        m_busy, m_age, m_owner, m_prio, m_win;
    logic [31:0] m_in1, m_data;
    logic        m_zero;
    logic [15:0] m_ops;
    logic [1:0]  exp_ready, exp_valid;
    logic [31:0] a_sel, b_sel;
    logic [4:0]  c_sel;
    logic        s_sel;

    initial begin
        ctl_tab[0] = 5'b00000; ctl_tab[1] = 5'b00001; ctl_tab[2] = 5'b00010;
        ctl_tab[3] = 5'b00110; ctl_tab[4] = 5'b00111; ctl_tab[5] = 5'b01100;

        // ---------------- reset state ----------------
        reset = 1'b1; req_valid = 2'b11; rsp_ready = 2'b11; req_sign = 2'b00;
        req_in1_0 = 32'd0; req_in1_1 = 32'd0; req_in2_0 = 32'd0; req_in2_1 = 32'd0;
        req_ctl_0 = 5'd0; req_ctl_1 = 5'd0;
        tick(); tick();
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_rsp_valid", rsp_valid, 2'b00);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_zero", rsp_zero, 1'b0);
        chk("rst_alu_in1", alu_in1, 32'd0);
        chk("rst_alu_ctl", alu_ctl, 5'd0);
        chk("rst_ops_done", ops_done, 16'd0);
        reset = 1'b0; req_valid = 2'b00;
        tick();

        // ---------------- single op: 5 + 7 ----------------
        req_in1_0 = 32'd5; req_in2_0 = 32'd7; req_ctl_0 = 5'b00010;
        req_valid = 2'b01; #1;
        chk("t1_ready", req_ready, 2'b01);
        tick();                                  // handshake edge T
        req_valid = 2'b00;
        chk("t1_exec_valid", rsp_valid, 2'b00);
        chk("t1_alu_in1", alu_in1, 32'd5);
        chk("t1_alu_in2", alu_in2, 32'd7);
        chk("t1_alu_ctl", alu_ctl, 5'b00010);
        req_valid = 2'b11; #1;
        chk("t1_exec_ready", req_ready, 2'b00);
        tick();                                  // T+1
        chk("t1_rsp_valid", rsp_valid, 2'b01);
        chk("t1_rsp_data", rsp_data, 32'd12);
        chk("t1_rsp_zero", rsp_zero, 1'b0);
        chk("t1_resp_ready", req_ready, 2'b00);
        req_valid = 2'b00;
        tick();                                  // T+2 response handshake
        chk("t1_done_valid", rsp_valid, 2'b00);
        chk("t1_ops_done", ops_done, 16'd1);

        // ---------------- simultaneous first request ----------------
        reset = 1'b1; tick(); reset = 1'b0;
        req_in1_0 = 32'd9;    req_in2_0 = 32'd9;    req_ctl_0 = 5'b00110;
        req_in1_1 = 32'hF0;   req_in2_1 = 32'h0F;   req_ctl_1 = 5'b00001;
        req_valid = 2'b11; #1;
        chk("t2_ready_first", req_ready, 2'b01);
        tick();
        req_valid = 2'b10;
        tick();
        chk("t2_r0_valid", rsp_valid, 2'b01);
        chk("t2_r0_data", rsp_data, 32'd0);
        chk("t2_r0_zero", rsp_zero, 1'b1);
        chk("t2_resp_ready", req_ready, 2'b00);
        tick();
        chk("t2_ready_second", req_ready, 2'b10);
        tick();
        req_valid = 2'b00;
        tick();
        chk("t2_r1_valid", rsp_valid, 2'b10);
        chk("t2_r1_data", rsp_data, 32'h0000_00FF);
        chk("t2_r1_zero", rsp_zero, 1'b0);
        tick();
        chk("t2_ops_done", ops_done, 16'd2);

        // ---------------- backpressure + operand isolation ----------------
        req_in1_0 = 32'h1234_5678; req_in2_0 = 32'h1111_1111; req_ctl_0 = 5'b00010;
        req_valid = 2'b01; rsp_ready = 2'b10;
        tick();                                  // accept
        req_in1_0 = 32'hDEAD_BEEF; req_valid = 2'b11;
        tick();                                  // now in RESP
        for (int i = 0; i < 3; i++) begin
            chk("t3_valid", rsp_valid, 2'b01);
            chk("t3_data", rsp_data, 32'h2345_6789);
            chk("t3_zero", rsp_zero, 1'b0);
            chk("t3_ready", req_ready, 2'b00);
            chk("t3_alu_in1", alu_in1, 32'h1234_5678);
            req_in1_0 = $urandom;
            tick();
        end
        chk("t3_hold_ops", ops_done, 16'd2);
        rsp_ready = 2'b01; req_valid = 2'b00;
        tick();
        chk("t3_done_valid", rsp_valid, 2'b00);
        chk("t3_ops_done", ops_done, 16'd3);

        // ---------------- reset during EXEC ----------------
        req_in1_0 = 32'd3; req_in2_0 = 32'd4; req_ctl_0 = 5'b00010; req_sign = 2'b11;
        req_valid = 2'b01; rsp_ready = 2'b11;
        tick();                                  // accept -> EXEC
        chk("t4_alu_sign", alu_sign, 1'b1);
        reset = 1'b1; req_valid = 2'b00;
        tick();
        chk("t4_rsp_valid", rsp_valid, 2'b00);
        chk("t4_rsp_data", rsp_data, 32'd0);
        chk("t4_alu_in1", alu_in1, 32'd0);
        chk("t4_alu_sign", alu_sign, 1'b0);
        chk("t4_ops_done", ops_done, 16'd0);
        reset = 1'b0; req_sign = 2'b00;
        tick(); tick();
        chk("t4_no_rsp", rsp_valid, 2'b00);
        chk("t4_ops_after", ops_done, 16'd0);

        // ---------------- round-robin, both continuously valid ----------------
        reset = 1'b1; tick(); reset = 1'b0;
        req_valid = 2'b11; rsp_ready = 2'b11;
        for (int k = 0; k < 12; k++) begin
            req_in1_0 = $urandom; req_in1_1 = $urandom;
            #1;
            chk("rr_onehot", req_ready == 2'b11, 1'b0);
            if (req_ready != 2'b00) grants.push_back(req_ready[1]);
            tick();
        end
        chk("rr_grant_count", grants.size(), 4);
        for (int k = 0; k < grants.size(); k++) chk("rr_order", grants[k], k % 2);
        chk("rr_ops_done", ops_done, 16'd4);

        // ---------------- randomized traffic vs reference model ----------------
        req_valid = 2'b00;
        reset = 1'b1; tick(); reset = 1'b0;
        m_busy = 1'b0; m_age = 1'b0; m_owner = 1'b0; m_prio = 1'b0;
        m_in1 = 32'd0; m_data = 32'd0; m_zero = 1'b0; m_ops = 16'd0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            req_valid = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            req_in1_0 = $urandom; req_in1_1 = $urandom;
            req_in2_0 = ($urandom_range(0, 3) == 0) ? req_in1_0 : $urandom;
            req_in2_1 = ($urandom_range(0, 3) == 0) ? req_in1_1 : $urandom;
            req_ctl_0 = ctl_tab[$urandom_range(0, 5)];
            req_ctl_1 = ctl_tab[$urandom_range(0, 5)];
            req_sign  = 2'($urandom_range(0, 3));
            rsp_ready = 2'($urandom_range(0, 3));
            #1;
            // expected outputs for this cycle
            m_win = (req_valid == 2'b11) ? m_prio : req_valid[1];
            exp_ready = (!m_busy && req_valid != 2'b00) ? (m_win ? 2'b10 : 2'b01) : 2'b00;
            exp_valid = (m_busy && m_age) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
            chk("rnd_ready", req_ready, exp_ready);
            chk("rnd_valid", rsp_valid, exp_valid);
            chk("rnd_ops", ops_done, m_ops);
            chk("rnd_alu_in1", alu_in1, m_in1);
            if (exp_valid != 2'b00) begin
                chk("rnd_data", rsp_data, m_data);
                chk("rnd_zero", rsp_zero, m_zero);
            end
            // advance model across the coming edge
            if (exp_ready != 2'b00) begin
                a_sel = m_win ? req_in1_1 : req_in1_0;
                b_sel = m_win ? req_in2_1 : req_in2_0;
                c_sel = m_win ? req_ctl_1 : req_ctl_0;
                s_sel = req_sign[m_win];
                m_in1   = a_sel;
                m_data  = alu_f(a_sel, b_sel, c_sel, s_sel);
                m_zero  = (m_data == 32'd0);
                m_owner = m_win;
                m_busy  = 1'b1;
                m_age   = 1'b0;
            end else if (m_busy && !m_age) begin
                m_age = 1'b1;
            end else if (m_busy && rsp_ready[m_owner]) begin
                m_busy = 1'b0;
                m_ops  = m_ops + 16'd1;
                m_prio = ~m_owner;
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
